// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-cycle sequencer.
package pwm_pkg;

    localparam int PWM_SEQ_CH_NUM     = 4;
    localparam int PWM_SEQ_CRX_WIDTH  = 16;
    localparam int PWM_SEQ_FIFO_DEPTH = 8;
    localparam int PWM_SEQ_RPT_WIDTH  = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ARM,
        SEQ_RUN
    } pwm_seq_state_e;

endpackage

// File: rtl/pwm_seq_fifo.sv
// Frame FIFO with flush; accepts push and pop together even when full.
module pwm_seq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign rdata = mem[rptr];
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/pwm_duty_seq.sv
// Duty-cycle sequencer: pops one compare frame per due PWM period boundary
// and loads all channel compare values together.
module pwm_duty_seq
    import pwm_pkg::*;
#(
    parameter int CH_NUM     = PWM_SEQ_CH_NUM,
    parameter int CRX_WIDTH  = PWM_SEQ_CRX_WIDTH,
    parameter int FIFO_DEPTH = PWM_SEQ_FIFO_DEPTH,
    parameter int RPT_WIDTH  = PWM_SEQ_RPT_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            en_i,
    input  logic                            loop_i,
    input  logic                            clr_i,
    input  logic [RPT_WIDTH-1:0]            rpt_i,
    input  logic                            ovf_i,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [CH_NUM*CRX_WIDTH-1:0]     wr_data_i,
    output logic [CH_NUM*CRX_WIDTH-1:0]     cr_o,
    output logic                            cr_upd_o,
    output logic [$clog2(FIFO_DEPTH):0]     level_o,
    output logic                            underrun_o,
    output logic                            busy_o
);

    localparam int FW = CH_NUM * CRX_WIDTH;

    pwm_seq_state_e       state, state_nxt;
    logic [RPT_WIDTH-1:0] rep_cnt;
    logic [FW-1:0]        head;
    logic [FW-1:0]        fifo_wdata;
    logic                 full, empty;
    logic                 due, pop, recirc, push, fifo_push;

    // A boundary is "due" when a new frame should be taken; clr_i masks it.
    assign due = en_i & ovf_i & ~clr_i &
                 ((state == SEQ_ARM) | ((state == SEQ_RUN) & (rep_cnt == '0)));
    assign pop        = due & ~empty;
    assign recirc     = loop_i & pop;
    assign wr_ready_o = ~full & ~clr_i & ~recirc;
    assign push       = wr_valid_i & wr_ready_o;
    assign fifo_push  = push | recirc;
    assign fifo_wdata = recirc ? head : wr_data_i;
    assign busy_o     = (state != SEQ_IDLE);

    pwm_seq_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .flush (clr_i),
        .push  (fifo_push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= SEQ_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en_i) begin
            state_nxt = SEQ_IDLE;
        end else begin
            case (state)
                SEQ_IDLE: state_nxt = SEQ_ARM;
                SEQ_ARM:  if (pop) state_nxt = SEQ_RUN;
                SEQ_RUN:  state_nxt = SEQ_RUN;
                default:  state_nxt = SEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cr_o       <= '0;
            cr_upd_o   <= 1'b0;
            rep_cnt    <= '0;
            underrun_o <= 1'b0;
        end else begin
            cr_upd_o <= pop;
            if (pop) begin
                cr_o    <= head;
                rep_cnt <= rpt_i;
            end else if (!en_i) begin
                rep_cnt <= '0;
            end else if (ovf_i && !clr_i && state == SEQ_RUN && rep_cnt != '0) begin
                rep_cnt <= rep_cnt - 1'b1;
            end
            // Only a running sequencer underruns; ARM just waits for data.
            if (clr_i)
                underrun_o <= 1'b0;
            else if (due && empty && state == SEQ_RUN)
                underrun_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Directed bench for pwm_duty_seq with hand-computed expectations.
module tb_pwm_duty_seq;

    localparam int FW = 64;
    localparam int LW = 4;
    localparam int RW = 8;

    localparam logic [FW-1:0] FA = 64'h0001_0002_0003_0004;
    localparam logic [FW-1:0] FB = 64'h0010_0020_0030_0040;
    localparam logic [FW-1:0] FC = 64'h0100_0200_0300_0400;
    localparam logic [FW-1:0] FD = 64'h0DDD_0DDD_0DDD_0DDD;
    localparam logic [FW-1:0] FX = 64'h0000_0000_0000_BEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, loop = 1'b0, clr = 1'b0, ovf = 1'b0, wr_valid = 1'b0;
    logic [RW-1:0] rpt = '0;
    logic [FW-1:0] wr_data = '0;
    logic          wr_ready, cr_upd, underrun, busy;
    logic [FW-1:0] cr;
    logic [LW-1:0] level;

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;
    int upd_base;

    pwm_duty_seq dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .loop_i     (loop),
        .clr_i      (clr),
        .rpt_i      (rpt),
        .ovf_i      (ovf),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_data_i  (wr_data),
        .cr_o       (cr),
        .cr_upd_o   (cr_upd),
        .level_o    (level),
        .underrun_o (underrun),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cr_upd) upd_cnt++;

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [FW-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse();
        ovf = 1'b1;
        step();
        ovf = 1'b0;
    endtask

    task automatic cleanup();
        en = 1'b0;
        loop = 1'b0;
        rpt = '0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    logic [FW-1:0] exp_rpt  [6] = '{FA, FA, FA, FB, FB, FB};
    logic [FW-1:0] exp_loop [7] = '{FA, FB, FC, FA, FB, FC, FA};

    initial begin
        // reset
        repeat (3) step();
        chk("rst_cr", cr, '0);
        chk("rst_upd", 64'(cr_upd), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 64'(wr_ready), 64'd1);

        // basic load
        push(FA);
        push(FB);
        chk("basic_level2", 64'(level), 64'd2);
        en = 1'b1;
        step();
        chk("basic_busy", 64'(busy), 64'd1);
        pulse();
        chk("basic_crA", cr, FA);
        chk("basic_updA", 64'(cr_upd), 64'd1);
        chk("basic_level1", 64'(level), 64'd1);
        step();
        chk("basic_upd_low", 64'(cr_upd), 64'd0);
        pulse();
        chk("basic_crB", cr, FB);
        chk("basic_updB", 64'(cr_upd), 64'd1);
        step();
        pulse();
        chk("basic_underrun", 64'(underrun), 64'd1);
        chk("basic_hold", cr, FB);
        chk("basic_no_upd", 64'(cr_upd), 64'd0);
        step();
        cleanup();
        chk("clr_underrun", 64'(underrun), 64'd0);

        // repeat
        rpt = 8'd2;
        push(FA);
        push(FB);
        en = 1'b1;
        step();
        upd_base = upd_cnt;
        for (int k = 0; k < 6; k++) begin
            pulse();
            chk($sformatf("rpt_cr%0d", k + 1), cr, exp_rpt[k]);
            step();
        end
        chk("rpt_upd_count", 64'(upd_cnt - upd_base), 64'd2);
        chk("rpt_underrun", 64'(underrun), 64'd0);
        cleanup();

        // loop
        loop = 1'b1;
        push(FA);
        push(FB);
        push(FC);
        en = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            pulse();
            chk($sformatf("loop_cr%0d", k + 1), cr, exp_loop[k]);
            chk($sformatf("loop_level%0d", k + 1), 64'(level), 64'd3);
            step();
        end
        chk("loop_underrun", 64'(underrun), 64'd0);
        cleanup();

        // full / backpressure
        for (int i = 0; i < 8; i++) push(64'hF000 + 64'(i));
        chk("full_level", 64'(level), 64'd8);
        wr_valid = 1'b1;
        wr_data  = FX;
        #1;
        chk("full_ready", 64'(wr_ready), 64'd0);
        wr_valid = 1'b0;
        en = 1'b1;
        step();
        wr_valid = 1'b1;
        ovf = 1'b1;
        #1;
        chk("full_pop_ready", 64'(wr_ready), 64'd0);
        step();
        ovf = 1'b0;
        #1;
        chk("full_after_pop_level", 64'(level), 64'd7);
        chk("full_after_pop_cr", cr, 64'hF000);
        chk("full_after_pop_ready", 64'(wr_ready), 64'd1);
        step();
        wr_valid = 1'b0;
        chk("full_refill_level", 64'(level), 64'd8);

        // clear collision (still RUN, rep_cnt 0)
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("cc_flush_level", 64'(level), 64'd0);
        pulse();
        chk("cc_underrun_set", 64'(underrun), 64'd1);
        step();
        push(FA);
        push(FB);
        push(FC);
        chk("cc_level3", 64'(level), 64'd3);
        clr = 1'b1;
        wr_valid = 1'b1;
        wr_data = FD;
        ovf = 1'b1;
        #1;
        chk("cc_ready", 64'(wr_ready), 64'd0);
        step();
        clr = 1'b0;
        wr_valid = 1'b0;
        ovf = 1'b0;
        chk("cc_level0", 64'(level), 64'd0);
        chk("cc_no_upd", 64'(cr_upd), 64'd0);
        chk("cc_underrun_clr", 64'(underrun), 64'd0);
        chk("cc_cr_held", cr, 64'hF000);

        // disable then async reset
        push(FA);
        pulse();
        chk("dis_crA", cr, FA);
        step();
        pulse();
        chk("dis_underrun", 64'(underrun), 64'd1);
        step();
        en = 1'b0;
        step();
        chk("dis_busy", 64'(busy), 64'd0);
        chk("dis_cr_held", cr, FA);
        push(FB);
        pulse();
        chk("dis_ovf_ignored_cr", cr, FA);
        chk("dis_ovf_ignored_upd", 64'(cr_upd), 64'd0);
        step();
        chk("dis_level", 64'(level), 64'd1);
        chk("dis_underrun_kept", 64'(underrun), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cr", cr, '0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_underrun", 64'(underrun), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        #3;
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_seq.md
Name: pwm_duty_seq

Overview:
- Autonomous duty-cycle sequencer for the 4-channel APB4 PWM timer.
- Software or DMA pushes packed compare-value frames into an internal FIFO.
- At each PWM period boundary the block pops a frame and drives all channel compare registers together. Updates are therefore glitch-free, and a frame can be held for a programmable number of periods.
- Optional loop mode replays the queued pattern indefinitely. Sits between the APB register bank and the PWM counter/compare datapath, in the pclk domain.

Parameters:
- CH_NUM, 4, number of PWM channels per frame
- CRX_WIDTH, 16, width of one channel compare value
- FIFO_DEPTH, 8, frame entries; power of two, >= 2
- RPT_WIDTH, 8, width of the per-frame repeat count

Ports:
- clk_i  in  1  pclk domain clock
- rst_n_i  in  1  asynchronous active-low reset
- en_i  in  1  sequencer enable (level)
- loop_i  in  1  1 = popped frame is re-pushed to FIFO tail
- clr_i  in  1  synchronous flush: FIFO emptied, underrun cleared
- rpt_i  in  RPT_WIDTH  extra periods each frame is held (0 = new frame every period)
- ovf_i  in  1  one-cycle period-boundary pulse from PWM counter wrap, already synchronised to clk_i
- wr_valid_i  in  1  frame write request
- wr_ready_o  out  1  frame write accept
- wr_data_i  in  CH_NUM*CRX_WIDTH  packed frame, channel 0 in LSBs
- cr_o  out  CH_NUM*CRX_WIDTH  compare values to PWM channels
- cr_upd_o  out  1  one-cycle pulse when cr_o changes
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- underrun_o  out  1  sticky: boundary reached with no frame available
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: cr_o=0, cr_upd_o=0, level_o=0, underrun_o=0, busy_o=0, state IDLE, rep_cnt=0, FIFO pointers 0.
- Write handshake: push when wr_valid_i & wr_ready_o. wr_ready_o = ~full & ~clr_i & ~recirc.
  - recirc = loop_i & pop in this cycle.
  - wr_ready_o is combinational on ovf_i and carries no combinational path from wr_valid_i.
  - When full, there is no write-through even if a pop occurs in the same cycle.
- Pop condition p = en_i & ovf_i & ~empty & (state==ARM | (state==RUN & rep_cnt==0)).
- State machine:
  - IDLE: en_i=1 -> ARM next cycle. FIFO accepts writes in every state.
  - ARM: on ovf_i with FIFO non-empty -> pop, load, rep_cnt<=rpt_i, go RUN. On ovf_i with FIFO empty -> stay ARM; underrun is not flagged.
  - RUN, ovf_i with rep_cnt!=0: rep_cnt decrements, cr_o holds.
  - RUN, ovf_i with rep_cnt==0 and FIFO non-empty: pop, load, rep_cnt<=rpt_i.
  - RUN, ovf_i with rep_cnt==0 and FIFO empty: underrun_o<=1, cr_o holds, stay RUN, retry at next ovf_i.
  - Any state, en_i=0: IDLE next cycle. cr_o, FIFO and underrun_o are kept; rep_cnt<=0.
- Load latency: ovf_i sampled at edge N -> cr_o updated and cr_upd_o high in cycle N+1 only. Only one pop can occur per ovf_i.
- Loop mode: on pop, the same frame is pushed to the tail in the same cycle, so level_o is unchanged. loop_i is sampled at pop time; changing it only affects later pops.
- level_o: +1 on push, -1 on pop without recirc, unchanged on push+pop or recirc.
- clr_i:
  - Has priority over push and pop in the same cycle; an ovf_i in that cycle is ignored.
  - Empties FIFO, sets level_o=0, clears underrun_o.
  - State and cr_o are unchanged; RUN then underruns at the next due boundary unless refilled.
- rpt_i is sampled at load time; a mid-frame change takes effect on the next frame.
- rep_cnt wraps never: it decrements only when non-zero.
- Asynchronous reset mid-operation returns everything to the reset values immediately; cr_o=0 forces all PWM outputs high, which is the documented safe state.

Decomposition:
- Shared package pwm_pkg: PWM_SEQ_FIFO_DEPTH, PWM_SEQ_RPT_WIDTH defaults, and typedef enum logic [1:0] {SEQ_IDLE, SEQ_ARM, SEQ_RUN} pwm_seq_state_e.
- Sub-module pwm_seq_fifo: synchronous FIFO with push/pop/flush, full/empty and level outputs.
- The controller FSM, repeat counter and cr_o register live in pwm_duty_seq.

Test Plan:
- Basic load: write frames A=0x0001_0002_0003_0004 and B=0x0010_0020_0030_0040, en_i=1, rpt_i=0, pulse ovf_i at 3 boundaries. Expect cr_o=A the cycle after the 1st ovf_i, then B after the 2nd, with cr_upd_o pulsing once each. The 3rd ovf_i sets underrun_o=1 and cr_o stays B.
- Repeat: rpt_i=2, frames A,B, 6 ovf_i pulses. Expect cr_o=A for ovf 1-3 and B from ovf 4; exactly 2 cr_upd_o pulses.
- Loop: loop_i=1, frames A,B,C, 7 ovf_i pulses. Expect the sequence A,B,C,A,B,C,A; level_o stays 3; underrun_o stays 0.
- Full/backpressure: push 8 frames with en_i=0. Expect wr_ready_o=0 and level_o=8. Then en_i=1 and ovf_i with wr_valid_i held: the write is not accepted in the pop cycle, is accepted the next cycle, and level_o returns to 8.
- Clear collision: clr_i and wr_valid_i and ovf_i asserted in the same cycle with 3 frames queued. Expect level_o=0, no cr_upd_o, the write dropped, and underrun_o cleared.
- Disable/reset: deassert en_i mid-RUN. Expect busy_o=0 next cycle, cr_o held, and ovf_i ignored. Assert rst_n_i low asynchronously between edges: cr_o=0, level_o=0 and underrun_o=0 immediately.
